// File: rtl/entity_scanline_scheduler.sv
// Scans packed entity words during horizontal blanking into a pending slot bank, commits the
// bank at end of line, and emits a registered, priority-resolved per-pixel sprite descriptor.
module entity_scanline_scheduler #(
  parameter int NUM_ENTITIES = 16,
  parameter int SLOTS        = 4,
  parameter int UPSCALE      = 5,
  parameter int TILE_SIZE    = 8,
  parameter int TILES_H      = 16,
  parameter int H_ACTIVE     = 640,
  parameter int H_TOTAL      = 800,
  parameter int V_ACTIVE     = 480,
  parameter int V_TOTAL      = 525
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_ENTITIES*14-1:0] entities_flat,
  input  logic [NUM_ENTITIES-1:0]    flip_mask,
  input  logic [9:0]                 counter_H,
  input  logic [9:0]                 counter_V,
  output logic                       out_valid,
  output logic [11:0]                out_entity,
  output logic                       overflow,
  output logic                       scan_busy
);
  localparam int KW = (NUM_ENTITIES > 1) ? $clog2(NUM_ENTITIES) : 1;
  localparam int CW = $clog2(SLOTS + 2);

  localparam logic [9:0]    HA     = 10'(H_ACTIVE);
  localparam logic [9:0]    HLAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]    VA     = 10'(V_ACTIVE);
  localparam logic [9:0]    VLAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]    TPX    = 10'(TILE_SIZE * UPSCALE);
  localparam logic [9:0]    UPS    = 10'(UPSCALE);
  localparam logic [9:0]    TH     = 10'(TILES_H);
  localparam logic [2:0]    CMAX   = 3'(TILE_SIZE - 1);
  localparam logic [KW-1:0] KLAST  = KW'(NUM_ENTITIES - 1);
  localparam logic [CW-1:0] CSLOTS = CW'(SLOTS);
  localparam logic [CW-1:0] CSAT   = CW'(SLOTS + 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;
  state_t state_q, state_d;

  logic [KW-1:0]    k_q;
  logic [CW-1:0]    cnt_q;
  logic             povf_q, ovf_q;
  logic [9:0]       tgt_q;
  logic [SLOTS-1:0] pv_q, av_q;
  logic [9:0]       px_q   [SLOTS];
  logic [2:0]       prow_q [SLOTS];
  logic [3:0]       pid_q  [SLOTS];
  logic [1:0]       por_q  [SLOTS];
  logic             pfl_q  [SLOTS];
  logic [9:0]       ax_q   [SLOTS];
  logic [2:0]       arow_q [SLOTS];
  logic [3:0]       aid_q  [SLOTS];
  logic [1:0]       aor_q  [SLOTS];
  logic             afl_q  [SLOTS];
  logic             out_valid_q;
  logic [11:0]      out_entity_q;

  logic             start, commit, scan_step, last, hit, store;
  logic [9:0]       tgt_next, ent_loc, ex, ey, ex0, ey0, trow_rem;
  logic [10:0]      ey_end;
  logic [2:0]       trow;
  logic [13:0]      ent;
  logic             ent_flip;
  logic [SLOTS-1:0] slot_sel;

  // A new blanking interval always (re)starts the scan, whatever state we are in.
  assign start     = (counter_H == HA);
  assign commit    = (state_q == S_DONE) && !start && (counter_H == HLAST);
  assign scan_step = (state_q == S_SCAN) && !start;
  assign last      = (k_q == KLAST);
  assign tgt_next  = (counter_V == VLAST) ? 10'd0 : counter_V + 10'd1;

  always_comb begin
    ent      = '0;
    ent_flip = 1'b0;
    for (int i = 0; i < NUM_ENTITIES; i++) begin
      if (k_q == KW'(i)) begin
        ent      = entities_flat[i*14 +: 14];
        ent_flip = flip_mask[i];
      end
    end
  end

  assign ent_loc  = {2'b00, ent[7:0]};
  assign ex       = ent_loc % TH;
  assign ey       = ent_loc / TH;
  assign ex0      = ex * TPX;
  assign ey0      = ey * TPX;
  assign ey_end   = {1'b0, ey0} + {1'b0, TPX};
  assign hit      = (ent[13:10] != 4'hF) && (tgt_q < VA) && (tgt_q >= ey0) && ({1'b0, tgt_q} < ey_end);
  assign trow_rem = tgt_q % TPX;
  assign trow     = 3'(trow_rem / UPS);
  assign store    = scan_step && hit && (cnt_q < CSLOTS);

  always_comb begin
    slot_sel = '0;
    for (int s = 0; s < SLOTS; s++) begin
      slot_sel[s] = store && (cnt_q == CW'(s));
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_SCAN;
    end else begin
      case (state_q)
        S_SCAN:  if (last) state_d = S_DONE;
        S_DONE:  if (commit) state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Per-pixel lookup: lowest-numbered active slot covering counter_H wins.
  logic        pix_hit;
  logic [11:0] pix_ent;
  logic [9:0]  off;
  logic [2:0]  c, col;

  always_comb begin
    pix_hit = 1'b0;
    pix_ent = 12'hFFF;
    off     = '0;
    c       = '0;
    col     = '0;
    if (counter_H < HA && counter_V < VA) begin
      for (int s = 0; s < SLOTS; s++) begin
        if (!pix_hit && av_q[s] && counter_H >= ax_q[s] &&
            {1'b0, counter_H} < ({1'b0, ax_q[s]} + {1'b0, TPX})) begin
          pix_hit = 1'b1;
          off     = counter_H - ax_q[s];
          c       = 3'(off / UPS);
          col     = afl_q[s] ? CMAX - c : c;
          pix_ent = {arow_q[s], col, aid_q[s], aor_q[s]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      cnt_q        <= '0;
      povf_q       <= 1'b0;
      pv_q         <= '0;
      av_q         <= '0;
      ovf_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_entity_q <= 12'hFFF;
    end else begin
      state_q <= state_d;
      if (start) begin
        k_q    <= '0;
        cnt_q  <= '0;
        povf_q <= 1'b0;
        pv_q   <= '0;
      end else if (scan_step) begin
        k_q  <= k_q + KW'(1);
        pv_q <= pv_q | slot_sel;
        if (hit && cnt_q != CSAT) cnt_q <= cnt_q + CW'(1);
        if (hit && cnt_q >= CSLOTS) povf_q <= 1'b1;
      end
      if (commit) begin
        av_q  <= pv_q;
        ovf_q <= povf_q;
      end
      out_valid_q  <= pix_hit;
      out_entity_q <= pix_ent;
    end
  end

  // Slot payloads carry no reset; their valid bits above gate every use.
  always_ff @(posedge clk) begin
    if (start) tgt_q <= tgt_next;
    for (int s = 0; s < SLOTS; s++) begin
      if (slot_sel[s]) begin
        px_q[s]   <= ex0;
        prow_q[s] <= trow;
        pid_q[s]  <= ent[13:10];
        por_q[s]  <= ent[9:8];
        pfl_q[s]  <= ent_flip;
      end
      if (commit) begin
        ax_q[s]   <= px_q[s];
        arow_q[s] <= prow_q[s];
        aid_q[s]  <= pid_q[s];
        aor_q[s]  <= por_q[s];
        afl_q[s]  <= pfl_q[s];
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_entity = out_entity_q;
  assign overflow   = ovf_q;
  assign scan_busy  = (state_q == S_SCAN);

endmodule

// File: tb/tb_entity_scanline_scheduler.sv
// Bench for entity_scanline_scheduler: directed line scenarios plus randomized entity sets,
// compared against a list-based model of per-line sprite selection and pixel lookup.
module tb_entity_scanline_scheduler;
  localparam int NE = 16;
  localparam int SL = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [NE*14-1:0] entities_flat;
  logic [NE-1:0]  flip_mask;
  logic [9:0]     counter_H, counter_V;
  logic           out_valid, overflow, scan_busy;
  logic [11:0]    out_entity;

  entity_scanline_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .entities_flat (entities_flat),
    .flip_mask     (flip_mask),
    .counter_H     (counter_H),
    .counter_V     (counter_V),
    .out_valid     (out_valid),
    .out_entity    (out_entity),
    .overflow      (overflow),
    .scan_busy     (scan_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tx;
    int row;
    int id;
    int ori;
    bit fl;
  } spr_t;

  spr_t m_act[$];
  spr_t m_pend[$];
  bit   m_ovf, m_povf;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sprites for a target line: every visible entity whose tile row contains the line, in index order.
  function automatic void model_scan(input int vs);
    int t, nh;
    logic [13:0] w;
    t  = (vs == 524) ? 0 : vs + 1;
    nh = 0;
    m_pend.delete();
    for (int k = 0; k < NE; k++) begin
      w = entities_flat[k*14 +: 14];
      if (w[13:10] != 4'hF && t < 480 && t / 40 == int'(w[7:0]) / 16) begin
        nh++;
        if (nh <= SL) m_pend.push_back('{int'(w[7:0]) % 16, (t % 40) / 5, int'(w[13:10]), int'(w[9:8]), flip_mask[k]});
      end
    end
    m_povf = (nh > SL);
  endfunction

  function automatic void exp_pix(input int h, input int v, output bit vld, output logic [11:0] e);
    int c, col;
    vld = 1'b0;
    e   = 12'hFFF;
    if (h < 640 && v < 480) begin
      foreach (m_act[i]) begin
        if (!vld && h / 40 == m_act[i].tx) begin
          c   = (h % 40) / 5;
          col = m_act[i].fl ? 7 - c : c;
          e   = {3'(m_act[i].row), 3'(col), 4'(m_act[i].id), 2'(m_act[i].ori)};
          vld = 1'b1;
        end
      end
    end
  endfunction

  task automatic step(input int h, input int v);
    counter_H = 10'(h);
    counter_V = 10'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic show_px(input int h, input int v);
    bit ev;
    logic [11:0] ee;
    step(h, v);
    exp_pix(h, v, ev, ee);
    chk($sformatf("px_vld h=%0d v=%0d", h, v), {31'd0, out_valid}, {31'd0, ev});
    chk($sformatf("px_ent h=%0d v=%0d", h, v), {20'd0, out_entity}, {20'd0, ee});
  endtask

  task automatic show_rand(input int v, input int n);
    int h;
    for (int i = 0; i < n; i++) begin
      h = ($urandom_range(0, 9) == 0) ? $urandom_range(641, 798) : $urandom_range(0, 639);
      show_px(h, v);
    end
  endtask

  task automatic run_h(input int vs, input int from, input int to, input bit chg);
    for (int h = from; h <= to; h++) begin
      if (h == 640) model_scan(vs);
      if (chg && h == 700) begin
        for (int k = 0; k < NE; k++) entities_flat[k*14 +: 14] = 14'($urandom);
        flip_mask = 16'($urandom);
      end
      step(h, vs);
      if (h == 642) chk("busy_scan", {31'd0, scan_busy}, 32'd1);
      if (h == 700) begin
        chk("busy_done", {31'd0, scan_busy}, 32'd0);
        chk("ovf_hold", {31'd0, overflow}, {31'd0, m_ovf});
        chk("blank_vld", {31'd0, out_valid}, 32'd0);
      end
      if (h == 799) begin
        m_act = m_pend;
        m_ovf = m_povf;
        chk("ovf_commit", {31'd0, overflow}, {31'd0, m_ovf});
      end
    end
  endtask

  task automatic set_ent(input int k, input int id, input int ori, input int loc);
    entities_flat[k*14 +: 14] = {4'(id), 2'(ori), 8'(loc)};
  endtask

  task automatic rand_ents(input int row, input int p);
    int id, y, x;
    for (int k = 0; k < NE; k++) begin
      id = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 14);
      y  = ($urandom_range(0, 7) < p) ? row : $urandom_range(0, 15);
      x  = $urandom_range(0, 15);
      entities_flat[k*14 +: 14] = {4'(id), 2'($urandom_range(0, 3)), 8'((y % 16) * 16 + x)};
    end
    flip_mask = 16'($urandom);
  endtask

  initial begin
    int vs, tt;
    entities_flat = '1;
    flip_mask     = '0;
    counter_H     = '0;
    counter_V     = '0;
    reset         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_ent", {20'd0, out_entity}, 32'hFFF);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_busy", {31'd0, scan_busy}, 32'd0);
    reset = 1'b1;
    step(0, 0);

    // single sprite at tile 17, line 41
    set_ent(0, 3, 1, 17);
    run_h(40, 640, 799, 1'b0);
    show_px(45, 41);
    chk("t2_ent", {20'd0, out_entity}, {20'd0, 3'd0, 3'd1, 4'h3, 2'b01});
    chk("t2_vld", {31'd0, out_valid}, 32'd1);
    show_px(80, 41);
    chk("t2_off", {31'd0, out_valid}, 32'd0);

    // mirrored
    flip_mask = 16'h0001;
    run_h(40, 640, 799, 1'b0);
    show_px(45, 41);
    chk("t3_col6", {20'd0, out_entity}, {20'd0, 3'd0, 3'd6, 4'h3, 2'b01});
    show_px(79, 41);
    chk("t3_col0", {20'd0, out_entity}, {20'd0, 3'd0, 3'd0, 4'h3, 2'b01});

    // overflowing bank on line 41, then reset in the middle of the next scan
    entities_flat = '1;
    flip_mask     = '0;
    for (int k = 0; k < 5; k++) set_ent(k, k + 1, 0, 16 + k);
    run_h(40, 640, 799, 1'b0);
    chk("t1_pre_ovf", {31'd0, overflow}, 32'd1);
    show_px(45, 41);
    run_h(40, 640, 646, 1'b0);
    reset = 1'b0;
    #1;
    chk("t1_busy", {31'd0, scan_busy}, 32'd0);
    chk("t1_ovf", {31'd0, overflow}, 32'd0);
    chk("t1_ent", {20'd0, out_entity}, 32'hFFF);
    chk("t1_vld", {31'd0, out_valid}, 32'd0);
    m_act.delete();
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    show_px(45, 41);
    chk("t1_after", {31'd0, out_valid}, 32'd0);
    show_rand(41, 20);
    run_h(40, 640, 799, 1'b0);
    show_px(45, 41);
    chk("t1_rescan", {31'd0, out_valid}, 32'd1);

    // two entities on one tile: lower index wins
    entities_flat = '1;
    set_ent(2, 5, 2, 18);
    set_ent(7, 9, 3, 18);
    run_h(49, 640, 799, 1'b0);
    show_px(85, 50);
    chk("t4_prio", {20'd0, out_entity}, {20'd0, 3'd2, 3'd1, 4'h5, 2'b10});

    // five hits on tile row 0
    entities_flat = '1;
    for (int k = 0; k < 5; k++) set_ent(k, k + 1, 0, k);
    run_h(9, 640, 799, 1'b0);
    chk("t5_ovf", {31'd0, overflow}, 32'd1);
    show_px(125, 10);
    chk("t5_slot3", {31'd0, out_valid}, 32'd1);
    show_px(165, 10);
    chk("t5_slot4", {31'd0, out_valid}, 32'd0);
    show_rand(10, 30);
    entities_flat = '1;
    run_h(20, 640, 799, 1'b0);
    chk("t5_clear", {31'd0, overflow}, 32'd0);

    // invisible ID, frame wrap, out-of-area target
    set_ent(0, 15, 0, 0);
    run_h(5, 640, 799, 1'b0);
    show_px(3, 6);
    chk("t6_idF", {31'd0, out_valid}, 32'd0);
    set_ent(0, 7, 2, 0);
    run_h(524, 640, 799, 1'b0);
    show_px(0, 0);
    chk("t6_wrap", {20'd0, out_entity}, {20'd0, 3'd0, 3'd0, 4'h7, 2'b10});
    run_h(479, 640, 799, 1'b0);
    show_px(0, 0);
    chk("t6_empty", {31'd0, out_valid}, 32'd0);

    // randomized lines, sometimes with an interrupted earlier scan
    for (int t = 0; t < 30; t++) begin
      vs = $urandom_range(0, 524);
      tt = (vs == 524) ? 0 : vs + 1;
      rand_ents(tt / 40, $urandom_range(1, 6));
      if ($urandom_range(0, 3) == 0) run_h($urandom_range(0, 524), 640, 640 + $urandom_range(2, 150), 1'b0);
      run_h(vs, 640, 799, 1'($urandom_range(0, 1)));
      show_rand(tt, 60);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
